ooo_fetch: RTL

Parametrised front-end fetch unit for the out-of-order core. It owns the PC and issues aligned instruction-memory reads of `IMEM_WIDTH` bits. Each response is split into 32-bit instructions and pushed into a `QUEUE_DEPTH`-entry instruction queue, which the decoder drains one instruction per cycle. Backend redirects flush the queue and drop any in-flight response, so stale instructions are never delivered after a redirect.

---
 rtl/ooo_fetch_pkg.sv | 20 ++
 rtl/ooo_fetch_queue.sv | 57 +++++
 rtl/ooo_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ooo_fetch_pkg.sv
// Shared types for the out-of-order front end: fetch FSM states and the
// instruction-queue entry format.
package ooo_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_down(input logic [31:0] addr, input int bytes);
    return addr & ~(32'(bytes) - 32'd1);
  endfunction

endpackage

// File: rtl/ooo_fetch_queue.sv
// Circular instruction queue: up to ENQ_WIDTH entries written per cycle,
// one entry read per cycle, synchronous flush.
module fetch_queue
  import ooo_fetch_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [$clog2(ENQ_WIDTH+1)-1:0] enq_n,
  input  fetch_entry_t                   enq_data [ENQ_WIDTH],
  input  logic                           deq_ready,
  output logic                           deq_valid,
  output fetch_entry_t                   deq_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             deq_fire;

  assign deq_valid = (count != '0);
  assign deq_fire  = deq_valid && deq_ready;
  // Head is masked when empty so stale entries never leak onto the outputs.
  assign deq_data  = deq_valid ? mem[head] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (i < int'(enq_n)) begin
          mem[tail + PTR_W'(i)] <= enq_data[i];
        end
      end
      tail  <= tail + PTR_W'(enq_n);
      head  <= head + PTR_W'(deq_fire);
      count <= count + CNT_W'(enq_n) - CNT_W'(deq_fire);
    end
  end

endmodule

// File: rtl/ooo_fetch.sv
// Front-end fetch unit: owns the PC, issues aligned imem reads, splits each
// response into 32-bit instructions and queues them for the decoder.
module ooo_fetch
  import ooo_fetch_pkg::*;
#(
  parameter int          IMEM_WIDTH  = 64,
  parameter int          QUEUE_DEPTH = 16,
  parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [31:0]           imem_addr,
  output logic [3:0]            imem_rmask,
  input  logic [IMEM_WIDTH-1:0] imem_rdata,
  input  logic                  imem_resp,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [31:0]           deq_inst,
  output logic [31:0]           deq_pc
);

  localparam int INSTS_PER_FETCH = IMEM_WIDTH / 32;
  localparam int BLOCK_BYTES     = IMEM_WIDTH / 8;
  localparam int CNT_W           = $clog2(QUEUE_DEPTH + 1);
  localparam int ENQ_N_W         = $clog2(INSTS_PER_FETCH + 1);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [31:0]        pc;
  logic [31:0]        pc_next;
  logic [31:0]        pc_block;
  logic [31:0]        slot_offset;
  logic               resp_kept;
  logic               issue;
  logic               deq_fire;
  int                 free_space;
  logic [ENQ_N_W-1:0] enq_n;
  fetch_entry_t       enq_data [INSTS_PER_FETCH];
  fetch_entry_t       head;
  logic [CNT_W-1:0]   queue_count;

  assign pc_block    = align_down(pc, BLOCK_BYTES);
  assign slot_offset = (pc >> 2) & 32'(INSTS_PER_FETCH - 1);
  assign resp_kept   = (state == WAIT) && imem_resp && !redirect_valid;
  assign deq_fire    = deq_valid && deq_ready;

  // Slot extraction: skip the slots below the PC, pack the rest to entry 0 up.
  always_comb begin
    enq_n = '0;
    for (int j = 0; j < INSTS_PER_FETCH; j++) begin
      enq_data[j] = '0;
    end
    if (resp_kept) begin
      enq_n = ENQ_N_W'(INSTS_PER_FETCH - int'(slot_offset));
      for (int j = 0; j < INSTS_PER_FETCH; j++) begin
        if (j + int'(slot_offset) < INSTS_PER_FETCH) begin
          enq_data[j].inst = imem_rdata[(j + int'(slot_offset))*32 +: 32];
          enq_data[j].pc   = pc_block + 32'((j + int'(slot_offset)) * 4);
        end
      end
    end
  end

  assign free_space = QUEUE_DEPTH - int'(queue_count) - int'(enq_n) + (deq_fire ? 1 : 0);
  assign issue      = !rst && !redirect_valid &&
                      ((state == IDLE) || ((state == WAIT) && imem_resp)) &&
                      (free_space >= INSTS_PER_FETCH);

  // A request issued in the response cycle already targets the next block.
  assign imem_addr  = ((state == WAIT) && imem_resp) ? pc_block + 32'(BLOCK_BYTES) : pc_block;
  assign imem_rmask = issue ? 4'hF : 4'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // A response landing in the redirect cycle is consumed right there, so only
  // a still-pending request needs DISCARD to swallow it later.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_valid) begin
      pc_next    = redirect_pc;
      state_next = (((state == WAIT) || (state == DISCARD)) && !imem_resp) ? DISCARD : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp) begin
            pc_next    = pc_block + 32'(BLOCK_BYTES);
            state_next = issue ? WAIT : IDLE;
          end
        end
        DISCARD: begin
          if (imem_resp) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH     (QUEUE_DEPTH),
    .ENQ_WIDTH (INSTS_PER_FETCH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .enq_n     (enq_n),
    .enq_data  (enq_data),
    .deq_ready (deq_ready),
    .deq_valid (deq_valid),
    .deq_data  (head),
    .count     (queue_count)
  );

  assign deq_inst = head.inst;
  assign deq_pc   = head.pc;

endmodule
